// File: rtl/aes_key_sched_ctrl_pkg.sv
// aes_key_sched_ctrl_pkg
//   Shared definitions for the AES-128 key-schedule sequencer:
//   controller state encoding, round-key count/width, and the
//   S-box / Rcon helpers used by the g-function.
package aes_key_sched_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    READY,
    STREAM
  } ks_state_e;

  localparam int unsigned NUM_RK  = 11;
  localparam logic [3:0]  LAST_RK = 4'd10;
  localparam int unsigned RK_W    = 128;

  // AES forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[(255 - int'(b)) * 8 +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] rc;
    case (r)
      4'd0:    rc = 8'h01;
      4'd1:    rc = 8'h02;
      4'd2:    rc = 8'h04;
      4'd3:    rc = 8'h08;
      4'd4:    rc = 8'h10;
      4'd5:    rc = 8'h20;
      4'd6:    rc = 8'h40;
      4'd7:    rc = 8'h80;
      4'd8:    rc = 8'h1b;
      4'd9:    rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/aes_key_sched_ctrl_gfunc.sv
// gFunction
//   AES key-expansion g-function: RotWord, SubWord, then Rcon XOR on the
//   top byte. Purely combinational.
//   i_Word   in  32 : last word of the previous round key
//   i_Round  in   4 : round index 0..9
//   i_fDec   in   1 : 1 = Rcon taken in reverse round order (backward expansion)
//   o_Word   out 32 : g(i_Word)
module gFunction
  import aes_key_sched_ctrl_pkg::*;
(
  input  logic [31:0] i_Word,
  input  logic [3:0]  i_Round,
  input  logic        i_fDec,
  output logic [31:0] o_Word
);

  logic [31:0] rot;
  logic [3:0]  rc_idx;

  always_comb begin
    rot    = {i_Word[23:0], i_Word[31:24]};
    rc_idx = i_fDec ? (4'd9 - i_Round) : i_Round;
    o_Word = {sbox(rot[31:24]) ^ rcon(rc_idx),
              sbox(rot[23:16]),
              sbox(rot[15:8]),
              sbox(rot[7:0])};
  end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl
//   AES-128 key-schedule sequencer. Expands a cipher key into an 11-entry
//   round-key buffer (one round per cycle through a single g-function),
//   then streams the round keys forward (0..10) or reverse (10..0) over a
//   valid/ready handshake.
//   i_Clk       in   1 : clock, rising edge
//   i_Rst_n     in   1 : asynchronous active-low reset
//   i_Start     in   1 : load i_Key and expand (IDLE/READY only)
//   i_Key       in 128 : cipher key
//   i_Req       in   1 : start streaming (READY only)
//   i_fDec      in   1 : stream order sampled with i_Req (1 = reverse)
//   i_RkReady   in   1 : consumer ready
//   o_RkValid   out  1 : o_RoundKey valid
//   o_RoundKey  out 128: current round key (0 when not streaming)
//   o_RkLast    out  1 : final beat of the stream
//   o_KeyReady  out  1 : buffer holds a complete schedule
//   o_Busy      out  1 : expanding or streaming
//   Build option: define KEYSCHED_ZEROIZE_EN to reset the buffer to zero and
//   clear entries 1..10 when rekeying from READY.
module aes_key_sched_ctrl
  import aes_key_sched_ctrl_pkg::*;
(
  input  logic          i_Clk,
  input  logic          i_Rst_n,
  input  logic          i_Start,
  input  logic [127:0]  i_Key,
  input  logic          i_Req,
  input  logic          i_fDec,
  input  logic          i_RkReady,
  output logic          o_RkValid,
  output logic [127:0]  o_RoundKey,
  output logic          o_RkLast,
  output logic          o_KeyReady,
  output logic          o_Busy
);

  ks_state_e       state_q, state_d;
  logic [3:0]      rnd_q, rnd_d;
  logic [3:0]      idx_q, idx_d;
  logic            dec_q, dec_d;
  logic            load_key;
  logic            wr_rk;
  logic            rk_last;

  logic [RK_W-1:0] rk_q [NUM_RK];
  logic [RK_W-1:0] cur_rk;
  logic [RK_W-1:0] next_rk;
  logic [31:0]     g_out;
  logic [31:0]     w4, w5, w6, w7;

  assign cur_rk = rk_q[rnd_q];

  gFunction u_gfunc (
    .i_Word  (cur_rk[31:0]),
    .i_Round (rnd_q),
    .i_fDec  (1'b0),
    .o_Word  (g_out)
  );

  always_comb begin
    w4      = cur_rk[127:96] ^ g_out;
    w5      = cur_rk[95:64]  ^ w4;
    w6      = cur_rk[63:32]  ^ w5;
    w7      = cur_rk[31:0]   ^ w6;
    next_rk = {w4, w5, w6, w7};
  end

  assign rk_last = dec_q ? (idx_q == 4'd0) : (idx_q == LAST_RK);

  always_comb begin
    state_d  = state_q;
    rnd_d    = rnd_q;
    idx_d    = idx_q;
    dec_d    = dec_q;
    load_key = 1'b0;
    wr_rk    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_Start) begin
          load_key = 1'b1;
          rnd_d    = '0;
          state_d  = EXPAND;
        end
      end
      EXPAND: begin
        wr_rk = 1'b1;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == 4'd9) state_d = READY;
      end
      READY: begin
        // Rekey takes priority over a simultaneous stream request.
        if (i_Start) begin
          load_key = 1'b1;
          rnd_d    = '0;
          state_d  = EXPAND;
        end else if (i_Req) begin
          dec_d   = i_fDec;
          idx_d   = i_fDec ? LAST_RK : 4'd0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (i_RkReady) begin
          if (rk_last) state_d = READY;
          else         idx_d   = dec_q ? (idx_q - 4'd1) : (idx_q + 4'd1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      idx_q   <= '0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      idx_q   <= idx_d;
      dec_q   <= dec_d;
    end
  end

`ifdef KEYSCHED_ZEROIZE_EN
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      for (int unsigned i = 0; i < NUM_RK; i++) rk_q[i] <= '0;
    end else begin
      if (load_key) begin
        rk_q[0] <= i_Key;
        // Stale round keys of the old schedule are wiped on rekey.
        if (state_q == READY) begin
          for (int unsigned i = 1; i < NUM_RK; i++) rk_q[i] <= '0;
        end
      end
      if (wr_rk) rk_q[rnd_q + 4'd1] <= next_rk;
    end
  end
`else
  always_ff @(posedge i_Clk) begin
    if (load_key) rk_q[0] <= i_Key;
    if (wr_rk)    rk_q[rnd_q + 4'd1] <= next_rk;
  end
`endif

  always_comb begin
    o_RkValid  = (state_q == STREAM);
    o_RoundKey = o_RkValid ? rk_q[idx_q] : '0;
    o_RkLast   = o_RkValid & rk_last;
    o_KeyReady = (state_q == READY);
    o_Busy     = (state_q == EXPAND) || (state_q == STREAM);
  end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
module tb_aes_key_sched_ctrl;

  logic         i_Clk;
  logic         i_Rst_n;
  logic         i_Start;
  logic [127:0] i_Key;
  logic         i_Req;
  logic         i_fDec;
  logic         i_RkReady;
  logic         o_RkValid;
  logic [127:0] o_RoundKey;
  logic         o_RkLast;
  logic         o_KeyReady;
  logic         o_Busy;

  aes_key_sched_ctrl dut (
    .i_Clk      (i_Clk),
    .i_Rst_n    (i_Rst_n),
    .i_Start    (i_Start),
    .i_Key      (i_Key),
    .i_Req      (i_Req),
    .i_fDec     (i_fDec),
    .i_RkReady  (i_RkReady),
    .o_RkValid  (o_RkValid),
    .o_RoundKey (o_RoundKey),
    .o_RkLast   (o_RkLast),
    .o_KeyReady (o_KeyReady),
    .o_Busy     (o_Busy)
  );

  initial begin
    i_Clk = 1'b0;
    forever #5 i_Clk = ~i_Clk;
  end

  typedef struct {
    logic [127:0] key;
    logic         last;
    bit           chk;
  } sb_entry_t;

  sb_entry_t    sb[$];
  int           checks = 0;
  int           errors = 0;
  logic [127:0] fips_rk [11];
  logic [127:0] key_fips;
  logic [127:0] key_seq;
  logic [127:0] key2_rk1;
  logic [127:0] key2_rk10;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake; checks hold while stalled.
  logic         stalled = 1'b0;
  logic [127:0] held;
  always @(negedge i_Clk) begin
    if (i_Rst_n && o_RkValid) begin
      if (stalled) check("stall_hold", o_RoundKey, held);
      if (i_RkReady) begin
        stalled = 1'b0;
        if (sb.size() == 0) begin
          check("unexpected_beat", {127'd0, o_RkValid}, 128'd0);
        end else begin
          sb_entry_t e;
          e = sb.pop_front();
          if (e.chk) check("beat_key", o_RoundKey, e.key);
          check("beat_last", {127'd0, o_RkLast}, {127'd0, e.last});
        end
      end else begin
        stalled = 1'b1;
        held    = o_RoundKey;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic do_start(input logic [127:0] k);
    i_Key   = k;
    i_Start = 1'b1;
    tick();
    i_Start = 1'b0;
  endtask

  task automatic do_req(input logic dec);
    i_fDec = dec;
    i_Req  = 1'b1;
    tick();
    i_Req  = 1'b0;
  endtask

  task automatic push(input logic [127:0] k, input logic last, input bit chk);
    sb_entry_t e;
    e.key  = k;
    e.last = last;
    e.chk  = chk;
    sb.push_back(e);
  endtask

  task automatic push_fips(input logic dec);
    for (int i = 0; i < 11; i++) push(fips_rk[dec ? 10 - i : i], (i == 10), 1'b1);
  endtask

  task automatic drain(input bit rnd);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      if (rnd) i_RkReady = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 128'(sb.size()), 128'd0);
      sb.delete();
    end
    i_RkReady = 1'b1;
  endtask

  task automatic wait_keyready();
    int n;
    n = 0;
    while (!o_KeyReady && n < 40) begin
      tick();
      n++;
    end
    check("keyready_wait", {127'd0, o_KeyReady}, 128'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    key_fips    = fips_rk[0];
    key_seq     = 128'h000102030405060708090a0b0c0d0e0f;
    key2_rk1    = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    key2_rk10   = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    i_Rst_n = 1'b0; i_Start = 1'b0; i_Key = '0; i_Req = 1'b0;
    i_fDec = 1'b0; i_RkReady = 1'b1;
    tick(); tick();
    check("rst_valid",    {127'd0, o_RkValid},  128'd0);
    check("rst_key",      o_RoundKey,           128'd0);
    check("rst_last",     {127'd0, o_RkLast},   128'd0);
    check("rst_keyready", {127'd0, o_KeyReady}, 128'd0);
    check("rst_busy",     {127'd0, o_Busy},     128'd0);
    i_Rst_n = 1'b1;
    tick();

    // i_Req in IDLE is ignored
    do_req(1'b0);
    check("idle_req_ignored", {127'd0, o_RkValid}, 128'd0);

    // Expansion timing: o_KeyReady exactly 11 cycles after sampling i_Start
    do_start(key_fips);
    check("expand_busy", {127'd0, o_Busy}, 128'd1);
    repeat (9) tick();
    check("keyready_early", {127'd0, o_KeyReady}, 128'd0);
    tick();
    check("keyready_t11", {127'd0, o_KeyReady}, 128'd1);
    check("ready_not_busy", {127'd0, o_Busy}, 128'd0);

    // Forward stream, ready held high
    i_RkReady = 1'b1;
    push_fips(1'b0);
    do_req(1'b0);
    check("fwd_valid_t1", {127'd0, o_RkValid}, 128'd1);
    drain(1'b0);
    check("fwd_busy_fall", {127'd0, o_Busy}, 128'd0);
    check("fwd_keyready", {127'd0, o_KeyReady}, 128'd1);

    // Reverse stream
    push_fips(1'b1);
    do_req(1'b1);
    check("rev_first_key", o_RoundKey, fips_rk[10]);
    drain(1'b0);
    check("rev_busy_fall", {127'd0, o_Busy}, 128'd0);

    // Random backpressure
    push_fips(1'b0);
    i_RkReady = 1'b0;
    do_req(1'b0);
    drain(1'b1);

    // i_Start mid-STREAM is ignored
    push_fips(1'b1);
    do_req(1'b1);
    repeat (3) tick();
    do_start(key_seq);
    check("midstream_busy", {127'd0, o_Busy}, 128'd1);
    drain(1'b0);
    check("midstream_keyready", {127'd0, o_KeyReady}, 128'd1);

    // Schedule unchanged after the ignored start
    push_fips(1'b0);
    do_req(1'b0);
    drain(1'b0);

    // i_Start mid-EXPAND is ignored
    do_start(key_fips);
    repeat (4) tick();
    do_start(key_seq);
    repeat (5) tick();
    check("midexp_keyready", {127'd0, o_KeyReady}, 128'd1);
    push_fips(1'b1);
    do_req(1'b1);
    drain(1'b0);

    // Reset at beat 5 of a forward stream
    for (int i = 0; i < 5; i++) push(fips_rk[i], 1'b0, 1'b1);
    do_req(1'b0);
    drain(1'b0);
    check("beat5_key", o_RoundKey, fips_rk[5]);
    #2 i_Rst_n = 1'b0;
    #1;
    check("arst_valid",    {127'd0, o_RkValid},  128'd0);
    check("arst_key",      o_RoundKey,           128'd0);
    check("arst_last",     {127'd0, o_RkLast},   128'd0);
    check("arst_keyready", {127'd0, o_KeyReady}, 128'd0);
    check("arst_busy",     {127'd0, o_Busy},     128'd0);
    tick();
    i_Rst_n = 1'b1;
    tick();
    do_req(1'b0);
    tick();
    check("post_rst_req_valid", {127'd0, o_RkValid}, 128'd0);
    check("post_rst_keyready",  {127'd0, o_KeyReady}, 128'd0);
    check("post_rst_busy",      {127'd0, o_Busy}, 128'd0);

    // Simultaneous i_Start and i_Req in READY: rekey wins
    do_start(key_fips);
    wait_keyready();
    i_Key   = key_seq;
    i_Start = 1'b1;
    i_Req   = 1'b1;
    i_fDec  = 1'b1;
    tick();
    i_Start = 1'b0;
    i_Req   = 1'b0;
    check("rekey_no_valid", {127'd0, o_RkValid},  128'd0);
    check("rekey_busy",     {127'd0, o_Busy},     128'd1);
    check("rekey_keyready", {127'd0, o_KeyReady}, 128'd0);
    wait_keyready();
    for (int i = 0; i < 11; i++) begin
      case (10 - i)
        10:      push(key2_rk10, 1'b0, 1'b1);
        1:       push(key2_rk1,  1'b0, 1'b1);
        0:       push(key_seq,   1'b1, 1'b1);
        default: push('0,        1'b0, 1'b0);
      endcase
    end
    do_req(1'b1);
    drain(1'b0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
